// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline stages.
package core_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned RegAddrWidth = 6;

  typedef logic [RegAddrWidth-1:0] reg_addr_t;

  typedef enum logic {
    StIdle,
    StWaitMem
  } wb_state_e;

endpackage

// File: rtl/wb_bypass.sv
// Forwards the pending register-file write onto one decode read port.
module wb_bypass
  import core_pkg::*;
#(
  parameter int unsigned addr_width_p = 6
) (
  input  logic                    wen_i,
  input  logic [addr_width_p-1:0] wa_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [addr_width_p-1:0] raddr_i,
  input  logic [DataWidth-1:0]    rval_i,
  output logic [DataWidth-1:0]    fwd_o
);

  always_comb begin
    fwd_o = rval_i;
    if (wen_i && (wa_i == raddr_i)) begin
      fwd_o = wdata_i;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: drives the register-file write port, waits on loads with a
// timeout, and bypasses the in-flight write onto decode read values.
module wb_stage
  import core_pkg::*;
#(
  parameter int unsigned addr_width_p = 6,
  parameter int unsigned timeout_p    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    wen_i,
  input  logic                    is_load_i,
  input  logic [addr_width_p-1:0] rd_i,
  input  logic [DataWidth-1:0]    alu_result_i,
  input  logic                    mem_valid_i,
  input  logic [DataWidth-1:0]    mem_data_i,
  output logic                    rf_wen_o,
  output logic [DataWidth-1:0]    rf_wa_o,
  output logic [DataWidth-1:0]    rf_write_data_o,
  input  logic [addr_width_p-1:0] rs_addr_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  input  logic [DataWidth-1:0]    rs_val_i,
  input  logic [DataWidth-1:0]    rd_val_i,
  output logic [DataWidth-1:0]    rs_fwd_o,
  output logic [DataWidth-1:0]    rd_fwd_o,
  output logic                    mem_timeout_o
);

  localparam int unsigned CntW = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(timeout_p - 1);

  wb_state_e                 state_q;
  logic [CntW-1:0]           cnt_q;
  logic                      rf_wen_q;
  logic [addr_width_p-1:0]   rf_wa_q;
  logic [DataWidth-1:0]      rf_data_q;
  logic                      timeout_q;
  logic [addr_width_p-1:0]   ld_rd_q;
  logic                      ld_wen_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rf_wen_q  <= 1'b0;
      rf_wa_q   <= '0;
      rf_data_q <= '0;
      timeout_q <= 1'b0;
      ld_rd_q   <= '0;
      ld_wen_q  <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse unless a write is issued below.
      rf_wen_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            if (is_load_i) begin
              ld_rd_q  <= rd_i;
              ld_wen_q <= wen_i;
              cnt_q    <= '0;
              state_q  <= StWaitMem;
            end else if (wen_i) begin
              rf_wen_q  <= 1'b1;
              rf_wa_q   <= rd_i;
              rf_data_q <= alu_result_i;
            end
          end
        end
        StWaitMem: begin
          // A response on the expiry cycle takes priority over the timeout.
          if (mem_valid_i) begin
            rf_wen_q  <= ld_wen_q;
            rf_wa_q   <= ld_rd_q;
            rf_data_q <= mem_data_i;
            state_q   <= StIdle;
          end else if (cnt_q == CntMax) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o         = (state_q == StIdle);
  assign rf_wen_o        = rf_wen_q;
  assign rf_wa_o         = {{(DataWidth - addr_width_p){1'b0}}, rf_wa_q};
  assign rf_write_data_o = rf_data_q;
  assign mem_timeout_o   = timeout_q;

  wb_bypass #(
    .addr_width_p(addr_width_p)
  ) u_bypass_rs (
    .wen_i  (rf_wen_q),
    .wa_i   (rf_wa_q),
    .wdata_i(rf_data_q),
    .raddr_i(rs_addr_i),
    .rval_i (rs_val_i),
    .fwd_o  (rs_fwd_o)
  );

  wb_bypass #(
    .addr_width_p(addr_width_p)
  ) u_bypass_rd (
    .wen_i  (rf_wen_q),
    .wa_i   (rf_wa_q),
    .wdata_i(rf_data_q),
    .raddr_i(rd_addr_i),
    .rval_i (rd_val_i),
    .fwd_o  (rd_fwd_o)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes (address, data, cycle) are
// queued when stimulus is driven and checked whenever rf_wen_o pulses.
module tb_wb_stage;
  import core_pkg::*;

  localparam int unsigned AW = 6;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i, ready_o, wen_i, is_load_i;
  logic [AW-1:0] rd_i, rs_addr_i, rd_addr_i;
  logic [31:0]   alu_result_i, mem_data_i, rs_val_i, rd_val_i;
  logic          mem_valid_i;
  logic          rf_wen_o, mem_timeout_o;
  logic [31:0]   rf_wa_o, rf_write_data_o, rs_fwd_o, rd_fwd_o;

  typedef struct {
    reg_addr_t   wa;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t sb[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  wb_stage #(
    .addr_width_p(AW),
    .timeout_p   (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .wen_i          (wen_i),
    .is_load_i      (is_load_i),
    .rd_i           (rd_i),
    .alu_result_i   (alu_result_i),
    .mem_valid_i    (mem_valid_i),
    .mem_data_i     (mem_data_i),
    .rf_wen_o       (rf_wen_o),
    .rf_wa_o        (rf_wa_o),
    .rf_write_data_o(rf_write_data_o),
    .rs_addr_i      (rs_addr_i),
    .rd_addr_i      (rd_addr_i),
    .rs_val_i       (rs_val_i),
    .rd_val_i       (rd_val_i),
    .rs_fwd_o       (rs_fwd_o),
    .rd_fwd_o       (rd_fwd_o),
    .mem_timeout_o  (mem_timeout_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every write pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rf_wen_o) begin
      if (sb.size() == 0) begin
        check("spurious_wen", {31'd0, rf_wen_o}, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wb_addr", rf_wa_o, {26'd0, e.wa});
        check("wb_data", rf_write_data_o, e.data);
        check("wb_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an ALU op; it is accepted on the next edge (stage assumed idle).
  task automatic drive_alu(input logic [AW-1:0] rd, input logic [31:0] res, input logic wen);
    valid_i = 1'b1; is_load_i = 1'b0; wen_i = wen; rd_i = rd; alu_result_i = res;
    if (wen) sb.push_back('{wa: rd, data: res, due: cyc + 1});
  endtask

  task automatic drive_load(input logic [AW-1:0] rd, input logic wen);
    valid_i = 1'b1; is_load_i = 1'b1; wen_i = wen; rd_i = rd; alu_result_i = $urandom;
  endtask

  task automatic push_mem(input logic [AW-1:0] rd, input logic [31:0] d, input int due);
    mem_valid_i = 1'b1; mem_data_i = d;
    sb.push_back('{wa: rd, data: d, due: due});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; valid_i = 1'b0; wen_i = 1'b0; is_load_i = 1'b0; rd_i = '0;
    alu_result_i = '0; mem_valid_i = 1'b0; mem_data_i = '0;
    rs_addr_i = 6'd4; rd_addr_i = 6'd9; rs_val_i = 32'h55; rd_val_i = 32'h66;
    repeat (3) tick();
    check("rst_wen", {31'd0, rf_wen_o}, 32'd0);
    check("rst_wa", rf_wa_o, 32'd0);
    check("rst_data", rf_write_data_o, 32'd0);
    check("rst_timeout", {31'd0, mem_timeout_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    reset = 1'b0;

    // Single ALU op, then three back-to-back.
    tick();
    drive_alu(6'd5, 32'hDEADBEEF, 1'b1);
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    for (int i = 1; i <= 3; i++) begin
      drive_alu(AW'(i), 32'(i * 10), 1'b1);
      tick();
      check("b2b_ready", {31'd0, ready_o}, 32'd1);
    end
    valid_i = 1'b0;
    repeat (2) tick();

    // Load answered in its fourth wait cycle, with an ALU op held behind it.
    drive_load(6'd7, 1'b1);
    tick();
    valid_i = 1'b1; is_load_i = 1'b0; wen_i = 1'b1; rd_i = 6'd8; alu_result_i = 32'h88;
    for (int i = 0; i < 4; i++) begin
      check("load_ready_low", {31'd0, ready_o}, 32'd0);
      if (i < 3) tick();
    end
    push_mem(6'd7, 32'h1234, cyc + 1);
    sb.push_back('{wa: 6'd8, data: 32'h88, due: cyc + 2});
    tick();
    mem_valid_i = 1'b0;
    check("load_ready_back", {31'd0, ready_o}, 32'd1);
    tick();
    valid_i = 1'b0;
    repeat (2) tick();

    // Load with no response times out.
    drive_load(6'd11, 1'b1);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("to_ready_low", {31'd0, ready_o}, 32'd0);
      check("to_flag_low", {31'd0, mem_timeout_o}, 32'd0);
      tick();
    end
    check("to_flag_set", {31'd0, mem_timeout_o}, 32'd1);
    check("to_ready_back", {31'd0, ready_o}, 32'd1);

    // Response on the expiry cycle still writes; flag unchanged.
    drive_load(6'd12, 1'b1);
    tick();
    valid_i = 1'b0;
    repeat (15) tick();
    push_mem(6'd12, 32'h5678, cyc + 1);
    tick();
    mem_valid_i = 1'b0;
    check("expiry_flag_kept", {31'd0, mem_timeout_o}, 32'd1);
    check("expiry_ready", {31'd0, ready_o}, 32'd1);
    tick();

    // Bypass on rs, then on rd, then no bypass.
    drive_alu(6'd4, 32'hAA, 1'b1);
    tick();
    valid_i = 1'b0;
    check("fwd_rs_hit", rs_fwd_o, 32'hAA);
    check("fwd_rd_miss", rd_fwd_o, 32'h66);
    drive_alu(6'd9, 32'hBB, 1'b1);
    tick();
    valid_i = 1'b0;
    check("fwd_rd_hit", rd_fwd_o, 32'hBB);
    check("fwd_rs_miss", rs_fwd_o, 32'h55);
    tick();
    check("fwd_idle_rs", rs_fwd_o, 32'h55);
    check("fwd_idle_rd", rd_fwd_o, 32'h66);

    // Register 0 passes through; wen_i=0 produces no write.
    drive_alu(6'd0, 32'h77, 1'b1);
    tick();
    drive_alu(6'd3, 32'h99, 1'b0);
    tick();
    valid_i = 1'b0;
    repeat (2) tick();

    // Reset while waiting on a load; a late response is ignored.
    drive_load(6'd13, 1'b1);
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_valid_i = 1'b1; mem_data_i = 32'hBAD;
    tick();
    mem_valid_i = 1'b0;
    check("rst_wait_timeout", {31'd0, mem_timeout_o}, 32'd0);
    check("rst_wait_ready", {31'd0, ready_o}, 32'd1);
    check("rst_wait_wen", {31'd0, rf_wen_o}, 32'd0);
    tick();

    // With the flag clear, an expiry-cycle response must not set it.
    drive_load(6'd14, 1'b1);
    tick();
    valid_i = 1'b0;
    repeat (15) tick();
    push_mem(6'd14, 32'hC0DE, cyc + 1);
    tick();
    mem_valid_i = 1'b0;
    check("expiry_no_flag", {31'd0, mem_timeout_o}, 32'd0);
    repeat (4) tick();
    check("sb_drain", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 3-stage core; sits directly upstream of the register file and drives its single write port (wen/wa/write_data).
- Accepts one retiring instruction per cycle from execute. ALU results write back after 1 cycle; loads wait for the data-memory response through a small state machine.
- Also bypasses the pending write onto the decode-stage read values. The register file writes synchronously, so a same-cycle read would otherwise return the stale value.

Parameters:
- addr_width_p, 6, register address width; must match the register file.
- timeout_p, 16, maximum cycles spent in WAIT_MEM before the load is abandoned; must be >= 2.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- valid_i  in  1  execute presents a retiring instruction
- ready_o  out  1  stage can accept; execute must hold its outputs while low
- wen_i  in  1  instruction writes a register
- is_load_i  in  1  result comes from data memory
- rd_i  in  addr_width_p  destination register
- alu_result_i  in  32  ALU result (ignored for loads)
- mem_valid_i  in  1  data-memory response valid
- mem_data_i  in  32  load data
- rf_wen_o  out  1  to register file wen_i
- rf_wa_o  out  32  to register file wa_i; rd zero-extended
- rf_write_data_o  out  32  to register file write_data_i
- rs_addr_i, rd_addr_i  in  addr_width_p  decode read addresses
- rs_val_i, rd_val_i  in  32  raw register file read values
- rs_fwd_o, rd_fwd_o  out  32  bypassed read values
- mem_timeout_o  out  1  sticky; a load was abandoned

Behaviour:
- Reset values: rf_wen_o=0, rf_wa_o=0, rf_write_data_o=0, mem_timeout_o=0, state=IDLE, timeout counter=0. ready_o=1 in the first cycle after reset.
- ready_o = (state==IDLE), combinational. The handshake fires on valid_i && ready_o.
- IDLE, handshake, non-load, wen_i=1: next cycle rf_wen_o=1, rf_wa_o={0,rd_i}, rf_write_data_o=alu_result_i. Latency is exactly 1 cycle. Back-to-back handshakes produce back-to-back writes.
- IDLE, handshake, wen_i=0: no write; rf_wen_o=0 next cycle.
- IDLE, handshake, is_load_i=1: latch rd_i and wen_i, clear the counter, go to WAIT_MEM. rf_wen_o=0 next cycle.
- WAIT_MEM, mem_valid_i=1: next cycle rf_wen_o = latched wen and rf_write_data_o=mem_data_i. Go to IDLE.
- WAIT_MEM, no response: the counter increments each cycle. When it reaches timeout_p-1 without mem_valid_i, set mem_timeout_o (sticky until reset), drop the write and go to IDLE.
- If mem_valid_i arrives on the same cycle the counter expires, the response wins: the write happens and mem_timeout_o is not set.
- mem_valid_i in IDLE is ignored.
- rf_wen_o is a 1-cycle pulse per write, never held.
- Register 0 gets no special treatment; writes to it are passed through.
- Bypass, combinational:
  - rs_fwd_o = rf_write_data_o if rf_wen_o && rf_wa_o[addr_width_p-1:0]==rs_addr_i, else rs_val_i.
  - rd_fwd_o uses the same rule against rd_addr_i and rd_val_i.
- Reset in WAIT_MEM: the pending load is discarded, with no write and no timeout flag. A late mem_valid_i after reset is ignored.

Decomposition:
- Shared package core_pkg:
  - wb_state_e enum {IDLE, WAIT_MEM}.
  - Localparam for data width (32).
  - Register-address typedef sized by addr_width_p's default.
- One natural sub-module: wb_bypass, the pure combinational compare/select. It is instanced twice, once for rs and once for rd.

Test Plan:
- Reset, then ALU op rd=5, result 0xDEADBEEF -> next cycle rf_wen_o=1, rf_wa_o=5, rf_write_data_o=0xDEADBEEF; following cycle rf_wen_o=0.
- Three back-to-back ALU ops to rd=1,2,3 with results 10,20,30 -> three consecutive write pulses in order; ready_o stays 1.
- Load rd=7, mem_valid_i after 3 cycles with 0x1234 -> ready_o=0 for 4 cycles, then rf_wen_o=1, wa=7, data=0x1234; a write to rd=8 held by execute lands the cycle after.
- Load with no response, timeout_p=16 -> no write, mem_timeout_o=1 from cycle 16 onward, ready_o returns to 1; a later load with mem_valid_i on the expiry cycle writes and leaves the flag unchanged.
- Pending write rd=4 data 0xAA with rs_addr_i=4, rs_val_i=0x55, rd_addr_i=9 -> rs_fwd_o=0xAA, rd_fwd_o=rd_val_i.
- Assert reset during WAIT_MEM, then pulse mem_valid_i -> no write, mem_timeout_o=0, ready_o=1.
